pipelined_adder: RTL and testbench

Parametrised, fully pipelined add/subtract unit. It is the multi-bit, clocked generalisation of the team's single-bit full adder. Operands are split into SEG-bit segments. Each pipeline stage adds one segment and registers its carry into the next stage, so wide adders close timing at high clock rates. It accepts one operation per cycle, supports a clock-enable stall, and reports carry-out and signed overflow aligned with the result.

---
 rtl/pipelined_adder.sv | 111 +++++++++++
 tb/tb_pipelined_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract unit split into SEG-bit segments,
// one segment per pipeline stage, with the carry registered between stages.
// Upper operand segments are skewed forward and finished lower segments are
// carried along, so every segment of an operation leaves the last stage
// together. WIDTH must be a positive multiple of SEG.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N = WIDTH / SEG;

  // Per-stage registers: valid bit, carry out of the stage's segment,
  // operand copies feeding later segments, and the partial result so far.
  logic [N-1:0]     valid_q;
  logic [N-1:0]     carry_q;
  logic [WIDTH-1:0] a_q   [N];
  logic [WIDTH-1:0] b_q   [N];
  logic [WIDTH-1:0] sum_q [N];
  logic             ovf_q;

  // Combinational stage inputs and results.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] a_in     [N];
  logic [WIDTH-1:0] b_in     [N];
  logic [N-1:0]     cy_in;
  logic [SEG:0]     seg_res  [N];
  logic [WIDTH-1:0] sum_next [N];
  logic             ovf_next;

  // Subtraction is a + ~b + ~c_in; the stage adders only ever add, and each
  // stage adds its own segment of the operands it received from the previous
  // stage plus that stage's registered carry.
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? ~c_in : c_in;

    a_in[0]  = a;
    b_in[0]  = b_eff;
    cy_in[0] = cin_eff;
    for (int k = 1; k < N; k++) begin
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      cy_in[k] = carry_q[k-1];
    end

    for (int k = 0; k < N; k++) begin
      seg_res[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                 + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, cy_in[k]};
    end

    sum_next[0] = '0;
    sum_next[0][SEG-1:0] = seg_res[0][SEG-1:0];
    for (int k = 1; k < N; k++) begin
      sum_next[k] = sum_q[k-1];
      sum_next[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
    end

    // The carry into the MSB is recovered as a ^ b ^ sum at that bit; it
    // differs from the carry out exactly when the signed result overflows.
    ovf_next = a_in[N-1][WIDTH-1] ^ b_in[N-1][WIDTH-1]
             ^ seg_res[N-1][SEG-1] ^ seg_res[N-1][SEG];
  end

  // Advance every stage on an enabled edge; reset clears all state and wins over ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (ce) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < N; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < N; k++) begin
        carry_q[k] <= seg_res[k][SEG];
        a_q[k]     <= a_in[k];
        b_q[k]     <= b_in[k];
        sum_q[k]   <= sum_next[k];
      end
      ovf_q <= ovf_next;
    end
  end

  assign out_valid = valid_q[N-1];
  assign sum       = sum_q[N-1];
  assign c_out     = carry_q[N-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for a 16-bit/4-bit-segment adder and
// a 4-bit/1-bit-segment adder sharing clock, reset and clock enable.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst, ce;

  logic        in_valid, sub, c_in;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out, ovf;

  logic       s_in_valid, s_sub, s_c_in;
  logic [3:0] s_a, s_b;
  logic       s_out_valid;
  logic [3:0] s_sum;
  logic       s_c_out, s_ovf;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        of;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int en_edges = 0;

  logic        last_ov  [2];
  logic [15:0] last_sum [2];
  logic        last_co  [2];
  logic        last_of  [2];

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut_wide (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .sum(sum),
    .c_out(c_out), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(4), .SEG(1)) dut_small (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(s_in_valid), .sub(s_sub),
    .a(s_a), .b(s_b), .c_in(s_c_in), .out_valid(s_out_valid), .sum(s_sum),
    .c_out(s_c_out), .ovf(s_ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference result from integer arithmetic: unsigned value for sum/carry,
  // signed range test for overflow.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb, input int due);
    exp_t   e;
    longint m, half, ux, uy, cl, full, sx, sy, r;
    m    = longint'(1) << w;
    half = m / 2;
    ux   = longint'(x);
    uy   = longint'(y);
    cl   = longint'(ci);
    full = sb ? (ux - uy - cl) : (ux + uy + cl);
    e.sum = 16'(full & (m - 1));
    e.co  = sb ? (full >= 0) : (full >= m);
    sx = (ux >= half) ? ux - m : ux;
    sy = (uy >= half) ? uy - m : uy;
    r  = sb ? (sx - sy - cl) : (sx + sy + cl);
    e.of  = (r >= half) || (r < -half);
    e.due = due;
    return e;
  endfunction

  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb);
    in_valid = 1'b1; a = x; b = y; c_in = ci; sub = sb;
    if (ce && !rst) q0.push_back(model(16, x, y, ci, sb, en_edges + 4));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic apply_small(input logic [3:0] x, input logic [3:0] y,
                             input logic ci, input logic sb);
    s_in_valid = 1'b1; s_a = x; s_b = y; s_c_in = ci; s_sub = sb;
    if (ce && !rst) q1.push_back(model(4, {12'd0, x}, {12'd0, y}, ci, sb, en_edges + 4));
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input int id, input logic ov, input logic [15:0] s,
                              input logic co, input logic of);
    exp_t e;
    int   qs;
    qs = (id == 0) ? q0.size() : q1.size();
    if (ov) begin
      checks++;
      if (qs == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out dut%0d got sum=%h c_out=%b ovf=%b, required no output",
                 id, s, co, of);
      end else begin
        if (id == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (s !== e.sum || co !== e.co || of !== e.of || en_edges != e.due) begin
          errors++;
          $display("[TB] FAIL result dut%0d got sum=%h c_out=%b ovf=%b at edge %0d, required sum=%h c_out=%b ovf=%b at edge %0d",
                   id, s, co, of, en_edges, e.sum, e.co, e.of, e.due);
        end
      end
    end else if (qs != 0) begin
      if (id == 0) e = q0[0];
      else e = q1[0];
      if (e.due <= en_edges) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_out dut%0d got out_valid=0 at edge %0d, required sum=%h",
                 id, en_edges, e.sum);
        if (id == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
  endtask

  // Monitor: after each rising edge, check reset values, frozen outputs on a
  // stalled edge, or scoreboard results on an enabled edge.
  always begin
    logic en_s, rst_s;
    logic        ov  [2];
    logic [15:0] sv  [2];
    logic        cov [2];
    logic        ofv [2];
    @(posedge clk);
    en_s  = ce;
    rst_s = rst;
    #1;
    ov[0] = out_valid;   sv[0] = sum;            cov[0] = c_out;   ofv[0] = ovf;
    ov[1] = s_out_valid; sv[1] = {12'd0, s_sum}; cov[1] = s_c_out; ofv[1] = s_ovf;
    for (int id = 0; id < 2; id++) begin
      if (rst_s) begin
        checks++;
        if (ov[id] !== 1'b0 || sv[id] !== 16'd0 || cov[id] !== 1'b0 || ofv[id] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset_state dut%0d got v=%b sum=%h c_out=%b ovf=%b, required all zero",
                   id, ov[id], sv[id], cov[id], ofv[id]);
        end
      end else if (!en_s) begin
        checks++;
        if (ov[id] !== last_ov[id] || sv[id] !== last_sum[id] ||
            cov[id] !== last_co[id] || ofv[id] !== last_of[id]) begin
          errors++;
          $display("[TB] FAIL stall_hold dut%0d got v=%b sum=%h c_out=%b ovf=%b, required v=%b sum=%h c_out=%b ovf=%b",
                   id, ov[id], sv[id], cov[id], ofv[id],
                   last_ov[id], last_sum[id], last_co[id], last_of[id]);
        end
      end
    end
    if (!rst_s && en_s) begin
      en_edges++;
      check_output(0, ov[0], sv[0], cov[0], ofv[0]);
      check_output(1, ov[1], sv[1], cov[1], ofv[1]);
    end
    for (int id = 0; id < 2; id++) begin
      last_ov[id] = ov[id]; last_sum[id] = sv[id];
      last_co[id] = cov[id]; last_of[id] = ofv[id];
    end
  end

  // Stimulus: directed cases, exhaustive small adder, then random traffic.
  initial begin
    int wait_cycles;
    rst = 1'b1; ce = 1'b1;
    in_valid = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    s_in_valid = 1'b0; s_sub = 1'b0; s_c_in = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);

    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    idle(6);

    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    idle(6);

    apply_stimulus(16'h000F, 16'h0001, 1'b0, 1'b0);
    apply_stimulus(16'h00F0, 16'h0010, 1'b0, 1'b0);
    apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    idle(6);

    apply_stimulus(16'h0FFF, 16'hF001, 1'b1, 1'b0);
    apply_stimulus(16'h1000, 16'h2000, 1'b1, 1'b1);
    apply_stimulus(16'hABCD, 16'h5432, 1'b0, 1'b0);
    ce = 1'b0;
    apply_stimulus(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    apply_stimulus(16'h1111, 16'h2222, 1'b1, 1'b1);
    apply_stimulus(16'h3333, 16'h4444, 1'b0, 1'b1);
    ce = 1'b1;
    idle(8);

    apply_stimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
    apply_stimulus(16'h2222, 16'h0002, 1'b0, 1'b1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    apply_stimulus(16'h4444, 16'h4444, 1'b0, 1'b0);
    rst = 1'b0;
    idle(6);
    apply_stimulus(16'h0002, 16'h0003, 1'b0, 1'b0);
    idle(6);

    for (int sb = 0; sb < 2; sb++) begin
      for (int i = 0; i < 512; i++) begin
        apply_small(4'(i), 4'(i >> 4), 1'((i >> 8) & 1), 1'(sb));
      end
    end
    idle(8);

    for (int i = 0; i < 300; i++) begin
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      else apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    ce = 1'b1;
    idle(1);

    wait_cycles = 0;
    while ((q0.size() != 0 || q1.size() != 0) && wait_cycles < 40) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d/%0d pending results, required 0/0", q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
